pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register, successor to the fixed-field stage registers between decode/execute/memory. Payload is split into three fields:
- data (zeroed on flush)
- ctrl (zeroed on flush; marks a bubble)
- keep (reloaded from input on flush, e.g. the PC)

Adds a valid/ready handshake for back-pressure (multi-cycle divide, memory stalls). An optional 2-entry skid buffer makes in_ready_o a pure register output. A saturating stall counter supports performance debug.

Parameters:
DATA_W, 128, width of flushable datapath field (operands, immediates, instruction)
CTRL_W, 16, width of flushable control field (ALU op, write enables, mem ctrl)
KEEP_W, 32, width of field preserved through flush (PC)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single register with combinational ready
CNT_W, 16, width of stall counter

Ports:
sys_clk  input  1  clock, all state on rising edge
sys_start  input  1  asynchronous active-low reset
flush_i  input  1  synchronous flush, drops stage contents
in_valid_i  input  1  upstream entry valid
in_ready_o  output  1  stage can accept an entry this cycle
in_data_i  input  DATA_W  upstream data field
in_ctrl_i  input  CTRL_W  upstream control field
in_keep_i  input  KEEP_W  upstream keep field
out_valid_o  output  1  downstream entry valid
out_ready_i  input  1  downstream accepts entry
out_data_o  output  DATA_W  head data field
out_ctrl_o  output  CTRL_W  head control field
out_keep_o  output  KEEP_W  head keep field
occupancy_o  output  2  entries held (0..2; max 1 when SKID=0)
stall_cnt_o  output  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating

Behaviour:
- Priority: reset > flush > normal operation.
- Reset (sys_start=0, async): all outputs 0, including in_ready_o, out_valid_o, occupancy_o and stall_cnt_o. Both entries are cleared and the state is EMPTY.
- First cycle after reset release: in_ready_o=1.
- Transfer rules:
  - in-transfer = in_valid_i & in_ready_o & ~flush_i
  - out-transfer = out_valid_o & out_ready_i & ~flush_i
- Latency: an entry accepted at edge N is presented on the out_* ports after edge N (1 cycle). No combinational path from in_* to out_*.
- SKID=1 state machine (main register M drives the outputs; skid register S):
  - EMPTY: in-transfer -> load M, go to ONE. in_ready_o=1.
  - ONE: in & out -> load M, stay ONE. In only -> load S, go to TWO. Out only -> go to EMPTY. in_ready_o=1.
  - TWO: out-transfer -> M<=S, go to ONE. in_ready_o=0. in_valid_i is ignored.
  - in_ready_o is a registered output: 1 in EMPTY/ONE, 0 in TWO.
  - Data order is strictly FIFO. No entry is lost or duplicated.
- SKID=0:
  - Single register M; states EMPTY/ONE only.
  - in_ready_o = ~out_valid_o | out_ready_i (combinational). This is the only combinational out->in path.
- Flush (flush_i=1 at an edge, any state):
  - S is discarded; state becomes EMPTY; out_valid_o=0.
  - out_data_o and out_ctrl_o are set to 0.
  - out_keep_o is loaded with in_keep_i, regardless of in_valid_i.
  - occupancy_o=0; in_ready_o=1 after the edge.
  - Flush overrides a simultaneous in- or out-transfer: neither takes effect.
  - stall_cnt_o is not cleared by flush.
- Outputs while EMPTY: out_data_o, out_ctrl_o and out_keep_o hold their last values, but out_valid_o=0. Downstream must qualify all fields with out_valid_o. After a flush those held values are zero (keep field = flushed PC).
- stall_cnt_o:
  - Increments by 1 on each edge where out_valid_o=1, out_ready_i=0 and flush_i=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- occupancy_o: 0/1/2 for EMPTY/ONE/TWO, registered.
- out_valid_o and occupancy_o are registered. No output glitches on in_valid_i changes (SKID=1).

Test Plan:
1. Reset mid-stream: hold 2 entries, assert sys_start=0 between edges -> out_valid_o=0, occupancy_o=0, stall_cnt_o=0 immediately; first edge after release gives in_ready_o=1.
2. Streaming (SKID=1, out_ready_i=1): push data 0x1..0x8 on consecutive cycles -> out_data_o = 0x1..0x8 one cycle later, in order; occupancy_o stays 1; stall_cnt_o=0.
3. Back-pressure: out_ready_i=0, push A, B, C -> occupancy 1, 2, then in_ready_o=0 and C is not accepted. Hold off 5 cycles -> stall_cnt_o=7. Raise out_ready_i -> A, B, then C (re-presented) exit in order.
4. Flush in TWO with in_keep_i=0x0000_0040, simultaneous in_valid_i=1 and out_ready_i=1 -> after the edge out_valid_o=0, out_ctrl_o=0, out_data_o=0, out_keep_o=0x40, occupancy_o=0; no entry is transferred.
5. Saturation with CNT_W=4: stall 20 cycles -> stall_cnt_o=15 and holds at 15; a subsequent flush leaves it at 15.
6. SKID=0 build: out_ready_i toggling randomly with 1000 random pushes -> scoreboard order matches; in_ready_o equals ~out_valid_o|out_ready_i every cycle; occupancy_o never exceeds 1.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Parametrised pipeline-stage register with a valid/ready handshake. It sits
// between pipeline stages such as decode/execute/memory. The payload has
// three fields:
//   data : datapath field, zeroed on flush
//   ctrl : control field, zeroed on flush (an all-zero ctrl is a bubble)
//   keep : field preserved through flush (e.g. the PC), reloaded from input
//
// With SKID=1 a second (skid) register lets in_ready_o come straight from a
// flop. With SKID=0 there is a single register, and ready is computed
// combinationally from the downstream ready.
//
// Ports:
//   sys_clk      : clock, all state updates on the rising edge
//   sys_start    : asynchronous active-low reset
//   flush_i      : synchronous flush, drops the stage contents
//   in_valid_i   : upstream entry valid
//   in_ready_o   : stage can accept an entry this cycle
//   in_data_i    : upstream data field   [DATA_W]
//   in_ctrl_i    : upstream control field [CTRL_W]
//   in_keep_i    : upstream keep field   [KEEP_W]
//   out_valid_o  : downstream entry valid
//   out_ready_i  : downstream accepts the entry
//   out_data_o   : head data field
//   out_ctrl_o   : head control field
//   out_keep_o   : head keep field
//   occupancy_o  : entries held (0..2, at most 1 when SKID=0)
//   stall_cnt_o  : saturating count of cycles with out_valid_o & ~out_ready_i
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int KEEP_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_start,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [KEEP_W-1:0] in_keep_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [KEEP_W-1:0] out_keep_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q;
    state_t state_d;

    // Main register M drives the outputs; skid register S holds the second entry.
    logic [DATA_W-1:0] m_data_q;
    logic [CTRL_W-1:0] m_ctrl_q;
    logic [KEEP_W-1:0] m_keep_q;
    logic [DATA_W-1:0] s_data_q;
    logic [CTRL_W-1:0] s_ctrl_q;
    logic [KEEP_W-1:0] s_keep_q;

    logic             in_ready_q;
    logic             out_valid_q;
    logic [1:0]       occ_q;
    logic [CNT_W-1:0] stall_q;

    logic in_xfer;
    logic out_xfer;
    logic load_m_in;
    logic load_s;
    logic load_m_skid;

    // in_ready_q is 1 in EMPTY/ONE and 0 in TWO. It is also 0 during reset
    // and stays 0 until the first edge after release.
    // Without a skid buffer, the registered term only gates the reset period.
    // Ready then follows downstream ready combinationally.
    assign in_ready_o = (SKID != 0) ? in_ready_q
                                    : (in_ready_q & (~out_valid_q | out_ready_i));

    assign in_xfer  = in_valid_i  & in_ready_o  & ~flush_i;
    assign out_xfer = out_valid_q & out_ready_i & ~flush_i;

    always_comb begin
        state_d     = state_q;
        load_m_in   = 1'b0;
        load_s      = 1'b0;
        load_m_skid = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        load_m_in = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    // With SKID=0, ready in ONE requires out_ready_i.
                    // An in-only transfer therefore cannot happen there.
                    if (in_xfer && out_xfer) begin
                        load_m_in = 1'b1;
                    end else if (in_xfer && (SKID != 0)) begin
                        load_s  = 1'b1;
                        state_d = TWO;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        load_m_skid = 1'b1;
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // On a flush, data and ctrl are zeroed to form a bubble.
    // The keep field is reloaded from the input, so the flushed PC stays visible.
    // The skid entry is simply discarded.
    always_ff @(posedge sys_clk or negedge sys_start) begin
        if (!sys_start) begin
            state_q     <= EMPTY;
            m_data_q    <= '0;
            m_ctrl_q    <= '0;
            m_keep_q    <= '0;
            s_data_q    <= '0;
            s_ctrl_q    <= '0;
            s_keep_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
            case (state_d)
                ONE:     occ_q <= 2'd1;
                TWO:     occ_q <= 2'd2;
                default: occ_q <= 2'd0;
            endcase
            if (flush_i) begin
                m_data_q <= '0;
                m_ctrl_q <= '0;
                m_keep_q <= in_keep_i;
                s_data_q <= '0;
                s_ctrl_q <= '0;
                s_keep_q <= '0;
            end else begin
                if (load_m_in) begin
                    m_data_q <= in_data_i;
                    m_ctrl_q <= in_ctrl_i;
                    m_keep_q <= in_keep_i;
                end else if (load_m_skid) begin
                    m_data_q <= s_data_q;
                    m_ctrl_q <= s_ctrl_q;
                    m_keep_q <= s_keep_q;
                end
                if (load_s) begin
                    s_data_q <= in_data_i;
                    s_ctrl_q <= in_ctrl_i;
                    s_keep_q <= in_keep_i;
                end
            end
        end
    end

    // The stall counter is cleared only by reset.
    // It saturates at its maximum value instead of wrapping.
    always_ff @(posedge sys_clk or negedge sys_start) begin
        if (!sys_start) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready_i && !flush_i && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = m_data_q;
    assign out_ctrl_o  = m_ctrl_q;
    assign out_keep_o  = m_keep_q;
    assign occupancy_o = occ_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Three instances share one set of inputs:
//   dut     : SKID=1, 16-bit stall counter (reset, streaming, back-pressure, flush)
//   dut_sat : SKID=1, 4-bit stall counter (saturation)
//   dut0    : SKID=0 (random handshake against a queue model)
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int KW = 32;

    logic          sys_clk   = 1'b0;
    logic          sys_start = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic [CW-1:0] in_ctrl   = '0;
    logic [KW-1:0] in_keep   = '0;

    logic          a_in_ready, a_out_valid;
    logic [DW-1:0] a_data;
    logic [CW-1:0] a_ctrl;
    logic [KW-1:0] a_keep;
    logic [1:0]    a_occ;
    logic [15:0]   a_stall;

    logic          b_in_ready, b_out_valid;
    logic [DW-1:0] b_data;
    logic [CW-1:0] b_ctrl;
    logic [KW-1:0] b_keep;
    logic [1:0]    b_occ;
    logic [3:0]    b_stall;

    logic          c_in_ready, c_out_valid;
    logic [DW-1:0] c_data;
    logic [CW-1:0] c_ctrl;
    logic [KW-1:0] c_keep;
    logic [1:0]    c_occ;
    logic [15:0]   c_stall;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .KEEP_W(KW), .SKID(1), .CNT_W(16)) dut (
        .sys_clk(sys_clk), .sys_start(sys_start), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .in_keep_i(in_keep),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready),
        .out_data_o(a_data), .out_ctrl_o(a_ctrl), .out_keep_o(a_keep),
        .occupancy_o(a_occ), .stall_cnt_o(a_stall)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .KEEP_W(KW), .SKID(1), .CNT_W(4)) dut_sat (
        .sys_clk(sys_clk), .sys_start(sys_start), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(b_in_ready),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .in_keep_i(in_keep),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready),
        .out_data_o(b_data), .out_ctrl_o(b_ctrl), .out_keep_o(b_keep),
        .occupancy_o(b_occ), .stall_cnt_o(b_stall)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .KEEP_W(KW), .SKID(0), .CNT_W(16)) dut0 (
        .sys_clk(sys_clk), .sys_start(sys_start), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(c_in_ready),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .in_keep_i(in_keep),
        .out_valid_o(c_out_valid), .out_ready_i(out_ready),
        .out_data_o(c_data), .out_ctrl_o(c_ctrl), .out_keep_o(c_keep),
        .occupancy_o(c_occ), .stall_cnt_o(c_stall)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                 input logic [CW-1:0] c, input logic [KW-1:0] k,
                                 input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        in_keep   = k;
        out_ready = r;
        flush     = f;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] q[$];
        int            pushes;
        int            cycles;
        logic          exp_ready;

        // Reset state
        sys_start = 1'b0;
        applyStimulus(0, '0, '0, '0, 0, 0);
        tick();
        tick();
        checkOutput("rst_valid", a_out_valid, 0);
        checkOutput("rst_ready", a_in_ready, 0);
        checkOutput("rst_occ", a_occ, 0);
        checkOutput("rst_stall", a_stall, 0);
        sys_start = 1'b1;
        tick();
        checkOutput("rel_ready", a_in_ready, 1);
        checkOutput("rel_valid", a_out_valid, 0);

        // Streaming with downstream always ready
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, DW'(i), CW'(i), KW'(32'h100 + i), 1, 0);
            tick();
            checkOutput("stream_valid", a_out_valid, 1);
            checkOutput("stream_data", a_data, 64'(i));
            checkOutput("stream_keep", a_keep, 64'(32'h100 + i));
            checkOutput("stream_occ", a_occ, 1);
            checkOutput("stream_ready", a_in_ready, 1);
        end
        applyStimulus(0, '0, '0, '0, 1, 0);
        tick();
        checkOutput("drain_valid", a_out_valid, 0);
        checkOutput("drain_hold", a_data, 8);
        checkOutput("stream_stall", a_stall, 0);

        // Back-pressure: A, B, C with downstream stalled
        applyStimulus(1, 32'hA, 8'h1, 32'h200, 0, 0);
        tick();
        checkOutput("bp_occA", a_occ, 1);
        applyStimulus(1, 32'hB, 8'h2, 32'h204, 0, 0);
        tick();
        checkOutput("bp_occB", a_occ, 2);
        checkOutput("bp_readyB", a_in_ready, 0);
        applyStimulus(1, 32'hC, 8'h3, 32'h208, 0, 0);
        tick();
        checkOutput("bp_occC", a_occ, 2);
        checkOutput("bp_headA", a_data, 32'hA);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("bp_stall7", a_stall, 7);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_headB", a_data, 32'hB);
        checkOutput("bp_occ1", a_occ, 1);
        checkOutput("bp_stall_hold", a_stall, 7);
        tick();
        checkOutput("bp_headC", a_data, 32'hC);
        checkOutput("bp_ctrlC", a_ctrl, 8'h3);
        applyStimulus(0, '0, '0, '0, 1, 0);
        tick();
        checkOutput("bp_empty", a_out_valid, 0);

        // Flush while holding two entries
        applyStimulus(1, 32'hD, 8'h4, 32'h300, 0, 0);
        tick();
        applyStimulus(1, 32'hE, 8'h5, 32'h304, 0, 0);
        tick();
        checkOutput("fl_occ2", a_occ, 2);
        applyStimulus(1, 32'hFF, 8'h5A, 32'h40, 1, 1);
        tick();
        checkOutput("fl_valid", a_out_valid, 0);
        checkOutput("fl_data", a_data, 0);
        checkOutput("fl_ctrl", a_ctrl, 0);
        checkOutput("fl_keep", a_keep, 32'h40);
        checkOutput("fl_occ", a_occ, 0);
        checkOutput("fl_ready", a_in_ready, 1);
        checkOutput("fl_stall", a_stall, 8);
        applyStimulus(0, '0, '0, 32'h99, 1, 0);
        tick();
        checkOutput("fl_after_valid", a_out_valid, 0);
        checkOutput("fl_after_keep", a_keep, 32'h40);

        // Reset mid-stream with two entries held
        applyStimulus(1, 32'h11, 8'h1, 32'h400, 0, 0);
        tick();
        applyStimulus(1, 32'h12, 8'h2, 32'h404, 0, 0);
        tick();
        checkOutput("mr_occ2", a_occ, 2);
        checkOutput("mr_stall", a_stall, 9);
        #2;
        sys_start = 1'b0;
        #1;
        checkOutput("mr_valid", a_out_valid, 0);
        checkOutput("mr_occ", a_occ, 0);
        checkOutput("mr_stall0", a_stall, 0);
        checkOutput("mr_data", a_data, 0);
        checkOutput("mr_ready", a_in_ready, 0);
        applyStimulus(0, '0, '0, '0, 0, 0);
        tick();
        sys_start = 1'b1;
        tick();
        checkOutput("mr_rel_ready", a_in_ready, 1);
        checkOutput("mr_rel_occ", a_occ, 0);

        // Stall counter saturation on the 4-bit instance
        applyStimulus(1, 32'h55, 8'h1, 32'h500, 0, 0);
        tick();
        checkOutput("sat_valid", b_out_valid, 1);
        applyStimulus(0, '0, '0, '0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) checkOutput("sat_mid", b_stall, 10);
        end
        checkOutput("sat_15", b_stall, 15);
        tick();
        tick();
        checkOutput("sat_hold", b_stall, 15);
        applyStimulus(0, '0, '0, 32'h600, 0, 1);
        tick();
        checkOutput("sat_flush_cnt", b_stall, 15);
        checkOutput("sat_flush_valid", b_out_valid, 0);
        checkOutput("sat_flush_keep", b_keep, 32'h600);

        // SKID=0 random handshake against a queue model.
        // The flush above left every instance empty.
        applyStimulus(0, '0, '0, '0, 0, 0);
        tick();
        checkOutput("s0_empty", c_out_valid, 0);
        pushes = 0;
        cycles = 0;
        while (pushes < 1000 && cycles < 5000) begin
            cycles++;
            applyStimulus(($urandom_range(0, 9) < 7), 32'h6000_0000 + pushes,
                          CW'(pushes), KW'(pushes), $urandom_range(0, 1) == 1, 0);
            #1;
            exp_ready = (q.size() == 0) || out_ready;
            checkOutput("s0_ready", c_in_ready, exp_ready);
            if ((q.size() != 0) && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) begin
                q.push_back(in_data);
                pushes++;
            end
            tick();
            checkOutput("s0_valid", c_out_valid, q.size() != 0);
            checkOutput("s0_occ", c_occ, q.size());
            if (q.size() != 0) checkOutput("s0_data", c_data, q[0]);
        end
        checkOutput("s0_pushes", pushes, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
